// File: rtl/sweep_acq_control_pkg.sv
// +------------------------------------------------------------------+
// | sweep_acq_control_pkg                                            |
// | Shared state encoding and default widths for the sweep control.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package sweep_acq_control_pkg;

    localparam int         DAC_W_DEF   = 10;
    localparam int         DATA_W_DEF  = 16;
    localparam logic [5:0] HDR_TAG_DEF = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD_SC     = 3'd1,
        ST_WAIT_CONFIG = 3'd2,
        ST_HEADER      = 3'd3,
        ST_ACQ         = 3'd4,
        ST_FLUSH       = 3'd5,
        ST_DAC_DONE    = 3'd6,
        ST_SWEEP_DONE  = 3'd7
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sweep_acq_readout.sv
// +------------------------------------------------------------------+
// | sweep_acq_readout                                                |
// | Package counter, FIFO read strobe and header/data output mux.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module sweep_acq_readout
    import sweep_acq_control_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              acq_active,
    input  logic              count_clr,
    input  logic              ParallelData_en,
    input  logic [DATA_W-1:0] max_pkg,
    input  logic              hdr_pulse,
    input  logic [DATA_W-1:0] hdr_word,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              last_pkg,
    output logic              rden,
    output logic [DATA_W-1:0] data_out,
    output logic              data_en
);

    logic [DATA_W-1:0] pkg_count;
    logic [DATA_W-1:0] count_inc;
    logic              data_valid;
    logic              take;

    assign take      = acq_active && ParallelData_en;
    assign count_inc = pkg_count + 1'b1;
    assign last_pkg  = take && (count_inc == max_pkg);

    always_ff @(posedge Clk) begin
        if (reset) begin
            pkg_count  <= '0;
            rden       <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            rden       <= take;
            data_valid <= rden;
            if (count_clr) begin
                pkg_count <= '0;
            end else if (take) begin
                pkg_count <= count_inc;
            end
        end
    end

    // FIFO word is valid the cycle after the strobe, so it is forwarded straight through.
    assign data_en  = hdr_pulse | data_valid;
    assign data_out = hdr_pulse ? hdr_word : (data_valid ? fifo_data : '0);

endmodule

`default_nettype wire

// File: rtl/sweep_acq_control.sv
// +------------------------------------------------------------------+
// | sweep_acq_control                                                |
// | Steps the DAC code from start to end, acquiring packages per step.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module sweep_acq_control
    import sweep_acq_control_pkg::*;
#(
    parameter int                        DAC_W   = DAC_W_DEF,
    parameter int                        DATA_W  = DATA_W_DEF,
    parameter logic [DATA_W-DAC_W-1:0]   HDR_TAG = HDR_TAG_DEF
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              SweepStart,
    output logic              SingleACQStart,
    output logic              OneDACDone,
    output logic              ACQDone,
    input  logic [DAC_W-1:0]  StartDAC0,
    input  logic [DAC_W-1:0]  EndDAC0,
    input  logic [DATA_W-1:0] MaxPackageNumber,
    input  logic              ParallelData_en,
    output logic [DAC_W-1:0]  OutDAC0,
    output logic              LoadSCParameter,
    input  logic              MicrorocConfigDone,
    input  logic [DATA_W-1:0] SweepACQFifoData,
    output logic              SweepACQFifoData_rden,
    output logic [DATA_W-1:0] SweepACQData,
    output logic              SweepACQData_en
);

    state_t            state;
    logic [DAC_W-1:0]  start_q;
    logic [DAC_W-1:0]  end_q;
    logic [DATA_W-1:0] max_q;
    logic              flush_cnt;
    logic              hdr_pulse;
    logic              last_pkg;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            start_q         <= '0;
            end_q           <= '0;
            max_q           <= '0;
            OutDAC0         <= '0;
            flush_cnt       <= 1'b0;
            hdr_pulse       <= 1'b0;
            LoadSCParameter <= 1'b0;
            SingleACQStart  <= 1'b0;
            OneDACDone      <= 1'b0;
            ACQDone         <= 1'b0;
        end else begin
            hdr_pulse       <= 1'b0;
            LoadSCParameter <= 1'b0;
            OneDACDone      <= 1'b0;
            ACQDone         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (SweepStart) begin
                        start_q         <= StartDAC0;
                        end_q           <= EndDAC0;
                        max_q           <= MaxPackageNumber;
                        OutDAC0         <= StartDAC0;
                        LoadSCParameter <= 1'b1;
                        state           <= ST_LOAD_SC;
                    end
                end
                ST_LOAD_SC: begin
                    state <= ST_WAIT_CONFIG;
                end
                ST_WAIT_CONFIG: begin
                    if (MicrorocConfigDone) begin
                        hdr_pulse <= 1'b1;
                        state     <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (max_q == '0) begin
                        OneDACDone <= 1'b1;
                        state      <= ST_DAC_DONE;
                    end else begin
                        SingleACQStart <= 1'b1;
                        state          <= ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    if (last_pkg) begin
                        SingleACQStart <= 1'b0;
                        flush_cnt      <= 1'b0;
                        state          <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt) begin
                        OneDACDone <= 1'b1;
                        state      <= ST_DAC_DONE;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                ST_DAC_DONE: begin
                    // Compare before incrementing so the code never wraps past the top.
                    if ((OutDAC0 == end_q) || (start_q > end_q)) begin
                        ACQDone <= 1'b1;
                        state   <= ST_SWEEP_DONE;
                    end else begin
                        OutDAC0         <= OutDAC0 + 1'b1;
                        LoadSCParameter <= 1'b1;
                        state           <= ST_LOAD_SC;
                    end
                end
                ST_SWEEP_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sweep_acq_readout #(
        .DATA_W (DATA_W)
    ) u_readout (
        .Clk             (Clk),
        .reset           (reset),
        .acq_active      (state == ST_ACQ),
        .count_clr       (state == ST_DAC_DONE),
        .ParallelData_en (ParallelData_en),
        .max_pkg         (max_q),
        .hdr_pulse       (hdr_pulse),
        .hdr_word        ({HDR_TAG, OutDAC0}),
        .fifo_data       (SweepACQFifoData),
        .last_pkg        (last_pkg),
        .rden            (SweepACQFifoData_rden),
        .data_out        (SweepACQData),
        .data_en         (SweepACQData_en)
    );

endmodule

`default_nettype wire

// File: tb/tb_sweep_acq_control.sv
// +------------------------------------------------------------------+
// | tb_sweep_acq_control                                             |
// | Directed and randomized sweeps checked against a sweep model.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_sweep_acq_control;

    logic        Clk = 1'b0;
    logic        reset;
    logic        SweepStart;
    logic        SingleACQStart;
    logic        OneDACDone;
    logic        ACQDone;
    logic [9:0]  StartDAC0;
    logic [9:0]  EndDAC0;
    logic [15:0] MaxPackageNumber;
    logic        ParallelData_en;
    logic [9:0]  OutDAC0;
    logic        LoadSCParameter;
    logic        MicrorocConfigDone;
    logic [15:0] SweepACQFifoData = 16'd0;
    logic        SweepACQFifoData_rden;
    logic [15:0] SweepACQData;
    logic        SweepACQData_en;

    int total = 0;
    int bad   = 0;

    int cfg_delay  = 8;
    bit cfg_enable = 1'b1;
    int pkg_max    = 0;
    int pkg_extra  = 0;

    logic [9:0]  loads_q[$];
    logic [15:0] words_q[$];
    int cyc = 0, n_done = 0, n_acq = 0, n_rden = 0, n_hi = 0, n_viol = 0;
    int done_cyc = 0, acq_cyc = 0, fifo_k = 0;
    logic prev_en = 1'b0;

    always #5 Clk = ~Clk;

    sweep_acq_control dut (
        .Clk                   (Clk),
        .reset                 (reset),
        .SweepStart            (SweepStart),
        .SingleACQStart        (SingleACQStart),
        .OneDACDone            (OneDACDone),
        .ACQDone               (ACQDone),
        .StartDAC0             (StartDAC0),
        .EndDAC0               (EndDAC0),
        .MaxPackageNumber      (MaxPackageNumber),
        .ParallelData_en       (ParallelData_en),
        .OutDAC0               (OutDAC0),
        .LoadSCParameter       (LoadSCParameter),
        .MicrorocConfigDone    (MicrorocConfigDone),
        .SweepACQFifoData      (SweepACQFifoData),
        .SweepACQFifoData_rden (SweepACQFifoData_rden),
        .SweepACQData          (SweepACQData),
        .SweepACQData_en       (SweepACQData_en)
    );

    // FIFO model: k-th read returns 3*k on the following cycle.
    always @(posedge Clk) begin
        if (SweepACQFifoData_rden) begin
            fifo_k           <= fifo_k + 1;
            SweepACQFifoData <= 16'(3 * (fifo_k + 1));
        end
    end

    always @(negedge Clk) begin
        cyc <= cyc + 1;
        if (LoadSCParameter) loads_q.push_back(OutDAC0);
        if (SweepACQData_en) words_q.push_back(SweepACQData);
        if (OneDACDone) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (ACQDone) begin
            n_acq   <= n_acq + 1;
            acq_cyc <= cyc;
        end
        if (SweepACQFifoData_rden) n_rden <= n_rden + 1;
        if (SingleACQStart) n_hi <= n_hi + 1;
        if (SweepACQData_en && prev_en) n_viol <= n_viol + 1;
        prev_en <= SweepACQData_en;
    end

    initial begin : cfg_resp
        MicrorocConfigDone = 1'b0;
        forever begin
            @(negedge Clk);
            if (LoadSCParameter && cfg_enable) begin
                repeat (cfg_delay) @(negedge Clk);
                MicrorocConfigDone = 1'b1;
                @(negedge Clk);
                MicrorocConfigDone = 1'b0;
            end
        end
    end

    initial begin : pkg_resp
        ParallelData_en = 1'b0;
        forever begin
            @(negedge Clk);
            if (SingleACQStart) begin
                for (int i = 0; i < pkg_max + pkg_extra; i++) begin
                    if (i < pkg_max && !SingleACQStart) break;
                    ParallelData_en = 1'b1;
                    @(negedge Clk);
                    ParallelData_en = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge Clk);
                end
                for (int w = 0; w < 100 && SingleACQStart; w++) @(negedge Clk);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [9:0] s, input logic [9:0] e, input logic [15:0] m);
        StartDAC0        = s;
        EndDAC0          = e;
        MaxPackageNumber = m;
        SweepStart       = 1'b1;
        @(negedge Clk);
        SweepStart       = 1'b0;
    endtask

    task automatic run_sweep(input logic [9:0] s, input logic [9:0] e, input int m,
                             input int extra, input string nm);
        int          lb, wb, db, ab, rb, hb, vb, fb, t;
        logic [9:0]  codes[$];
        logic [15:0] exp_w[$];
        lb = loads_q.size(); wb = words_q.size();
        db = n_done; ab = n_acq; rb = n_rden; hb = n_hi; vb = n_viol; fb = fifo_k;
        if (s > e) codes.push_back(s);
        else for (int d = int'(s); d <= int'(e); d++) codes.push_back(10'(d));
        foreach (codes[i]) begin
            exp_w.push_back({6'b111111, codes[i]});
            for (int k = 1; k <= m; k++) exp_w.push_back(16'(3 * (fb + i * m + k)));
        end
        pkg_max   = m;
        pkg_extra = extra;
        pulse_start(s, e, 16'(m));
        // Inputs changed and a second request issued mid-sweep must not disturb it.
        StartDAC0        = 10'($urandom);
        EndDAC0          = 10'($urandom);
        MaxPackageNumber = 16'($urandom_range(0, 50));
        @(negedge Clk);
        SweepStart = 1'b1;
        @(negedge Clk);
        SweepStart = 1'b0;
        t = 0;
        while (n_acq == ab && t < 20000) begin
            @(negedge Clk);
            t++;
        end
        chk({nm, " finished"}, 32'(t < 20000), 32'd1);
        repeat (12) @(negedge Clk);
        chk({nm, " loads"}, 32'(loads_q.size() - lb), 32'(codes.size()));
        for (int i = 0; i < codes.size() && lb + i < loads_q.size(); i++)
            chk({nm, " load code"}, 32'(loads_q[lb + i]), 32'(codes[i]));
        chk({nm, " words"}, 32'(words_q.size() - wb), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && wb + i < words_q.size(); i++)
            chk({nm, " word"}, 32'(words_q[wb + i]), 32'(exp_w[i]));
        chk({nm, " OneDACDone"}, 32'(n_done - db), 32'(codes.size()));
        chk({nm, " ACQDone"}, 32'(n_acq - ab), 32'd1);
        chk({nm, " rden"}, 32'(n_rden - rb), 32'(codes.size() * m));
        chk({nm, " acq active"}, 32'((n_hi - hb) != 0), 32'(m != 0));
        chk({nm, " en adjacency"}, 32'(n_viol - vb), 32'd0);
        chk({nm, " done order"}, 32'(acq_cyc > done_cyc), 32'd1);
        chk({nm, " final code"}, 32'(OutDAC0), 32'(codes[codes.size() - 1]));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " SingleACQStart"}, 32'(SingleACQStart), 32'd0);
        chk({nm, " OneDACDone"}, 32'(OneDACDone), 32'd0);
        chk({nm, " ACQDone"}, 32'(ACQDone), 32'd0);
        chk({nm, " LoadSC"}, 32'(LoadSCParameter), 32'd0);
        chk({nm, " OutDAC0"}, 32'(OutDAC0), 32'd0);
        chk({nm, " rden"}, 32'(SweepACQFifoData_rden), 32'd0);
        chk({nm, " data"}, 32'(SweepACQData), 32'd0);
        chk({nm, " data_en"}, 32'(SweepACQData_en), 32'd0);
    endtask

    initial begin : main
        int ab, rb, hb, lb, db, t, si, ei;
        logic [9:0] s, e;
        reset = 1'b1; SweepStart = 1'b0;
        StartDAC0 = '0; EndDAC0 = '0; MaxPackageNumber = '0;
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        chk_zero("reset");

        run_sweep(10'd500, 10'd505, 10, 0, "sweep500");
        run_sweep(10'd200, 10'd200, 1, 2, "single200");
        run_sweep(10'd10, 10'd11, 0, 0, "max0");
        run_sweep(10'd1022, 10'd1023, 2, 0, "top");
        run_sweep(10'd7, 10'd3, 3, 0, "reverse");

        // Abort during acquisition of DAC 502.
        ab = n_acq;
        pkg_max = 10; pkg_extra = 0;
        pulse_start(10'd500, 10'd505, 16'd10);
        t = 0;
        while (!(OutDAC0 == 10'd502 && SingleACQStart) && t < 5000) begin
            @(negedge Clk);
            t++;
        end
        chk("abort reached 502", 32'(t < 5000), 32'd1);
        repeat (4) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        chk_zero("abort");
        repeat (20) @(negedge Clk);
        chk("abort no ACQDone", 32'(n_acq - ab), 32'd0);
        run_sweep(10'd500, 10'd505, 10, 0, "restart");

        // Config completion withheld.
        cfg_enable = 1'b0;
        hb = n_hi; rb = n_rden; lb = loads_q.size(); db = n_done;
        pulse_start(10'd300, 10'd301, 16'd2);
        repeat (1000) @(negedge Clk);
        chk("hold acq", 32'(n_hi - hb), 32'd0);
        chk("hold rden", 32'(n_rden - rb), 32'd0);
        chk("hold loads", 32'(loads_q.size() - lb), 32'd1);
        chk("hold done", 32'(n_done - db), 32'd0);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        cfg_enable = 1'b1;
        repeat (3) @(negedge Clk);

        for (int r = 0; r < 3; r++) begin
            si = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0 && si > 0) ei = int'($urandom_range(0, si - 1));
            else ei = si + int'($urandom_range(0, 3));
            if (ei > 1023) ei = 1023;
            s = 10'(si);
            e = 10'(ei);
            cfg_delay = int'($urandom_range(1, 12));
            run_sweep(s, e, int'($urandom_range(0, 5)), int'($urandom_range(0, 1)), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
